// File: rtl/sprite_engine_if.sv
// Game-logic / pixel-writer side of the sprite engine: move and bullet inputs, the
// respawn request, and the plot/ready pixel handshake with its coordinates and colour.
interface sprite_engine_if #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 7,
    parameter int C_BITS = 3
);
    logic              move_tick;
    logic              dir_up;
    logic [C_BITS-1:0] sprite_color;
    logic              bullet_valid;
    logic [X_BITS-1:0] bullet_x;
    logic [Y_BITS-1:0] bullet_y;
    logic              respawn;
    logic [X_BITS-1:0] spawn_x;
    logic [Y_BITS-1:0] spawn_y;
    logic              plot_ready;
    logic              plot;
    logic [X_BITS-1:0] x_out;
    logic [Y_BITS-1:0] y_out;
    logic [C_BITS-1:0] color_out;
    logic              busy;
    logic              alive;

    modport master (
        output move_tick, dir_up, sprite_color, bullet_valid, bullet_x, bullet_y,
               respawn, spawn_x, spawn_y, plot_ready,
        input  plot, x_out, y_out, color_out, busy, alive
    );

    modport slave (
        input  move_tick, dir_up, sprite_color, bullet_valid, bullet_x, bullet_y,
               respawn, spawn_x, spawn_y, plot_ready,
        output plot, x_out, y_out, color_out, busy, alive
    );
endinterface

// File: rtl/sprite_engine.sv
// Single WxH sprite: erase / step / redraw on each move tick, erase-and-die on a bullet
// hit or on leaving past the top row, redraw at the spawn point on respawn.
module sprite_engine #(
    parameter int W      = 4,
    parameter int H      = 3,
    parameter int X_BITS = 8,
    parameter int Y_BITS = 7,
    parameter int C_BITS = 3,
    parameter int STEP   = 1,
    parameter int Y_MIN  = 1,
    parameter int Y_MAX  = 119 - H,
    parameter int X_INIT = 80,
    parameter int Y_INIT = 110,
    parameter int BW     = 4,
    parameter int BH     = 5
) (
    input logic           clk,
    input logic           resetn,
    sprite_engine_if.slave bus
);
    localparam int PXW = (W > 1) ? $clog2(W) : 1;
    localparam int PYW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ERASE = 3'd2,
        S_MOVE  = 3'd3,
        S_DRAW  = 3'd4,
        S_KILL  = 3'd5,
        S_DEAD  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [X_BITS-1:0] pos_x_q, pos_x_d;
    logic [Y_BITS-1:0] pos_y_q, pos_y_d;
    logic [PXW-1:0]    px_q, px_d;
    logic [PYW-1:0]    py_q, py_d;
    logic              alive_q, alive_d;
    logic              dir_up_q, dir_up_d;

    logic [X_BITS:0]   sx_w_s, bx_w_s;
    logic [Y_BITS:0]   sy_w_s, by_w_s;
    logic              hit_s;
    logic [Y_BITS:0]   y_up_s, y_dn_s, y_new_s;
    logic              y_kill_s;
    logic              last_s;

    // Overlap test one bit wider than the coordinates so edge sums never wrap.
    assign sx_w_s = {1'b0, pos_x_q};
    assign bx_w_s = {1'b0, bus.bullet_x};
    assign sy_w_s = {1'b0, pos_y_q};
    assign by_w_s = {1'b0, bus.bullet_y};
    assign hit_s  = bus.bullet_valid
                 && (bx_w_s < sx_w_s + (X_BITS+1)'(W))
                 && (sx_w_s < bx_w_s + (X_BITS+1)'(BW))
                 && (by_w_s < sy_w_s + (Y_BITS+1)'(H))
                 && (sy_w_s < by_w_s + (Y_BITS+1)'(BH));

    assign y_up_s = sy_w_s - (Y_BITS+1)'(STEP);
    assign y_dn_s = sy_w_s + (Y_BITS+1)'(STEP);
    assign last_s = (px_q == PXW'(W - 1)) && (py_q == PYW'(H - 1));

    // Candidate y after one step; an underflowed up-move shows as the extra top bit set.
    always_comb begin
        y_new_s = y_dn_s;
        if (dir_up_q) begin
            y_new_s = y_up_s;
        end else if (y_dn_s > (Y_BITS+1)'(Y_MAX)) begin
            y_new_s = (Y_BITS+1)'(Y_MAX);
        end else begin
            y_new_s = y_dn_s;
        end
        y_kill_s = y_new_s[Y_BITS] || (y_new_s < (Y_BITS+1)'(Y_MIN));
    end

    // Next-state, position, scan index and alive-flag logic.
    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        px_d     = px_q;
        py_d     = py_q;
        alive_d  = alive_q;
        dir_up_d = dir_up_q;
        case (state_q)
            S_INIT: state_d = S_DRAW;
            S_IDLE: begin
                if (hit_s) begin
                    state_d = S_KILL;
                    alive_d = 1'b0;
                end else if (bus.move_tick) begin
                    state_d  = S_ERASE;
                    dir_up_d = bus.dir_up;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERASE, S_DRAW, S_KILL: begin
                if (bus.plot_ready) begin
                    if (last_s) begin
                        px_d = '0;
                        py_d = '0;
                        case (state_q)
                            S_ERASE: state_d = S_MOVE;
                            S_DRAW:  state_d = S_IDLE;
                            default: state_d = S_DEAD;
                        endcase
                    end else if (px_q == PXW'(W - 1)) begin
                        px_d = '0;
                        py_d = py_q + PYW'(1);
                    end else begin
                        px_d = px_q + PXW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            // A fatal step leaves pos untouched so KILL erases where the sprite last was.
            S_MOVE: begin
                if (y_kill_s) begin
                    state_d = S_KILL;
                    alive_d = 1'b0;
                end else begin
                    pos_y_d = y_new_s[Y_BITS-1:0];
                    state_d = S_DRAW;
                end
            end
            S_DEAD: begin
                if (bus.respawn) begin
                    pos_x_d = bus.spawn_x;
                    pos_y_d = bus.spawn_y;
                    alive_d = 1'b1;
                    state_d = S_DRAW;
                end else begin
                    state_d = S_DEAD;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_INIT;
            pos_x_q  <= X_BITS'(X_INIT);
            pos_y_q  <= Y_BITS'(Y_INIT);
            px_q     <= '0;
            py_q     <= '0;
            alive_q  <= 1'b1;
            dir_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            px_q     <= px_d;
            py_q     <= py_d;
            alive_q  <= alive_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign bus.plot      = (state_q == S_ERASE) || (state_q == S_DRAW) || (state_q == S_KILL);
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DEAD);
    assign bus.color_out = (state_q == S_DRAW) ? bus.sprite_color : C_BITS'(0);
    assign bus.x_out     = pos_x_q + X_BITS'(px_q);
    assign bus.y_out     = pos_y_q + Y_BITS'(py_q);
    assign bus.alive     = alive_q;
endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: directed corner sequences, a constant-expectation vector table,
// and randomized transactions checked against a pixel-list reference model.
module tb_sprite_engine;
    localparam int W = 4, H = 3, STEP = 1, Y_MIN = 1, Y_MAX = 116, BW = 4, BH = 5;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sprite_engine_if #(.X_BITS(8), .Y_BITS(7), .C_BITS(3)) bus ();
    sprite_engine dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        bit tick; bit up; bit bv; int bx; int by;
        bit rsp; int sx; int sy;
        int n_erase; int n_draw; bit alive; int x; int y;
    } vec_t;

    pix_t got_q[$];
    pix_t exp_q[$];
    int   checks = 0, failures = 0, busy_cnt = 0, hold_err = 0;
    logic [7:0] prev_x;
    logic [6:0] prev_y;
    logic prev_stall = 1'b0;
    int   mx, my;
    bit   malive;
    vec_t tbl[19];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: sample outputs mid-cycle, log accepted pixels, then step past the edge.
    task automatic cycle();
        pix_t p;
        #1;
        if (bus.plot === 1'b1 && bus.plot_ready === 1'b1) begin
            p.x = bus.x_out; p.y = bus.y_out; p.c = bus.color_out;
            got_q.push_back(p);
        end
        if (prev_stall && bus.plot && (bus.x_out !== prev_x || bus.y_out !== prev_y)) hold_err++;
        prev_stall = bus.plot && !bus.plot_ready;
        prev_x = bus.x_out;
        prev_y = bus.y_out;
        if (bus.busy) busy_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.move_tick = 1'b0; bus.bullet_valid = 1'b0; bus.respawn = 1'b0;
    endtask

    task automatic run_idle(string name, bit rnd_ready);
        int n = 0;
        while (bus.busy && n < 400) begin
            if (rnd_ready) bus.plot_ready = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        bus.plot_ready = 1'b1;
        chk({name, "_timeout"}, bus.busy, 0);
    endtask

    task automatic add_rect(int x, int y, int c);
        pix_t p;
        for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++) begin
                p.x = 8'(x + i); p.y = 7'(y + j); p.c = 3'(c);
                exp_q.push_back(p);
            end
    endtask

    task automatic compare_q(string name);
        int bad = -1;
        checks++;
        if (got_q.size() != exp_q.size()) bad = 0;
        else
            for (int i = 0; i < got_q.size(); i++)
                if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: actual %0d pixels required %0d, first bad index %0d", name,
                     got_q.size(), exp_q.size(), bad);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic apply(bit tick, bit up, bit bv, int bx, int by, bit rsp, int sx, int sy, int c);
        bus.move_tick = tick; bus.dir_up = up; bus.bullet_valid = bv;
        bus.bullet_x = 8'(bx); bus.bullet_y = 7'(by);
        bus.respawn = rsp; bus.spawn_x = 8'(sx); bus.spawn_y = 7'(sy);
        bus.sprite_color = 3'(c);
        cycle();
        clear_inputs();
    endtask

    // Reference: what the pixel writer must receive for one request seen while idle/dead.
    task automatic model_step(bit tick, bit up, bit bv, int bx, int by, bit rsp, int sx, int sy, int c);
        int ny;
        bit hit;
        if (malive) begin
            hit = bv && (bx < mx + W) && (mx < bx + BW) && (by < my + H) && (my < by + BH);
            if (hit) begin
                add_rect(mx, my, 0);
                malive = 1'b0;
            end else if (tick) begin
                add_rect(mx, my, 0);
                ny = up ? my - STEP : ((my + STEP > Y_MAX) ? Y_MAX : my + STEP);
                if (ny < Y_MIN) begin
                    add_rect(mx, my, 0);
                    malive = 1'b0;
                end else begin
                    my = ny;
                    add_rect(mx, my, c);
                end
            end
        end else if (rsp) begin
            mx = sx; my = sy; malive = 1'b1;
            add_rect(mx, my, c);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, ne, nd, t;
        bit tick, up, bv, rsp;
        int bx, by, sx, sy, c;
        logic [3:0] pat;

        tbl[0]  = '{1,1,0,0,0,    0,0,0,    12,12,1,80,109};
        tbl[1]  = '{1,0,0,0,0,    0,0,0,    12,12,1,80,110};
        tbl[2]  = '{1,0,0,0,0,    0,0,0,    12,12,1,80,111};
        tbl[3]  = '{0,0,1,90,111, 0,0,0,     0, 0,1,80,111};
        tbl[4]  = '{1,0,1,76,111, 0,0,0,    12,12,1,80,112};
        tbl[5]  = '{1,0,1,83,114, 0,0,0,    12, 0,0,80,112};
        tbl[6]  = '{1,1,0,0,0,    0,0,0,     0, 0,0,80,112};
        tbl[7]  = '{0,0,0,0,0,    1,10,116,  0,12,1,10,116};
        tbl[8]  = '{1,0,0,0,0,    0,0,0,    12,12,1,10,116};
        tbl[9]  = '{0,0,0,0,0,    1,40,40,   0, 0,1,10,116};
        tbl[10] = '{1,1,1,6,112,  0,0,0,    12,12,1,10,115};
        tbl[11] = '{0,0,1,10,115, 0,0,0,    12, 0,0,10,115};
        tbl[12] = '{0,0,0,0,0,    1,10,1,    0,12,1,10,1};
        tbl[13] = '{1,1,0,0,0,    0,0,0,    24, 0,0,10,1};
        tbl[14] = '{1,0,0,0,0,    1,10,0,    0,12,1,10,0};
        tbl[15] = '{1,1,0,0,0,    0,0,0,    24, 0,0,10,0};
        tbl[16] = '{0,0,0,0,0,    1,10,50,   0,12,1,10,50};
        tbl[17] = '{1,1,1,10,45,  0,0,0,    12,12,1,10,49};
        tbl[18] = '{1,0,1,11,52,  0,0,0,    12,12,1,10,50};

        resetn = 1'b0;
        bus.plot_ready = 1'b1; bus.sprite_color = 3'd5; bus.dir_up = 1'b0;
        bus.bullet_x = 8'd0; bus.bullet_y = 7'd0; bus.spawn_x = 8'd0; bus.spawn_y = 7'd0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plot", bus.plot, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_color", bus.color_out, 0);
        chk("rst_x", bus.x_out, 80);
        chk("rst_y", bus.y_out, 110);
        chk("rst_alive", bus.alive, 1);

        resetn = 1'b1;
        busy_cnt = 0;
        run_idle("init", 1'b0);
        add_rect(80, 110, 5);
        compare_q("init_draw");
        chk("init_busy_cycles", busy_cnt, 13);

        busy_cnt = 0;
        apply(1, 1, 0, 0, 0, 0, 0, 0, 5);
        chk("tick_first_erase_plot", bus.plot, 1);
        chk("tick_first_erase_color", bus.color_out, 0);
        run_idle("up", 1'b0);
        add_rect(80, 110, 0);
        add_rect(80, 109, 5);
        compare_q("up_pixels");
        chk("up_busy_cycles", busy_cnt, 25);

        // Stall the writer 1,0,0,1 during the redraw only.
        hold_err = 0; k = 0; pat = 4'b1001;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 5);
        t = 0;
        while (bus.busy && t < 200) begin
            if (bus.color_out == 3'd5) begin
                bus.plot_ready = pat[k % 4];
                k++;
            end else begin
                bus.plot_ready = 1'b1;
            end
            cycle();
            t++;
        end
        bus.plot_ready = 1'b1;
        add_rect(80, 109, 0);
        add_rect(80, 110, 5);
        compare_q("stall_pixels");
        chk("stall_hold", hold_err, 0);
        chk("stall_draw_cycles", k, 24);

        apply(1, 1, 1, 82, 111, 0, 0, 0, 5);
        chk("kill_alive_at_entry", bus.alive, 0);
        run_idle("kill", 1'b0);
        add_rect(80, 110, 0);
        compare_q("kill_pixels");
        apply(1, 1, 0, 0, 0, 0, 0, 0, 5);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 5);
        compare_q("dead_ticks_no_plot");
        chk("dead_busy", bus.busy, 0);

        apply(0, 0, 0, 0, 0, 1, 10, 50, 5);
        chk("respawn_alive", bus.alive, 1);
        run_idle("respawn", 1'b0);
        add_rect(10, 50, 5);
        compare_q("respawn_pixels");

        apply(1, 0, 0, 0, 0, 0, 0, 0, 5);
        repeat (18) cycle();
        resetn = 1'b0;
        cycle();
        chk("midreset_x", bus.x_out, 80);
        chk("midreset_y", bus.y_out, 110);
        chk("midreset_plot", bus.plot, 0);
        chk("midreset_busy", bus.busy, 1);
        resetn = 1'b1;
        got_q.delete();
        busy_cnt = 0;
        run_idle("midreset", 1'b0);
        add_rect(80, 110, 5);
        compare_q("midreset_redraw");
        chk("midreset_busy_cycles", busy_cnt, 13);

        for (int i = 0; i < 19; i++) begin
            got_q.delete();
            apply(tbl[i].tick, tbl[i].up, tbl[i].bv, tbl[i].bx, tbl[i].by,
                  tbl[i].rsp, tbl[i].sx, tbl[i].sy, 5);
            run_idle($sformatf("vec%0d", i), 1'b0);
            ne = 0; nd = 0;
            foreach (got_q[j]) begin
                if (got_q[j].c == 3'd0) ne++;
                else nd++;
            end
            got_q.delete();
            chk($sformatf("vec%0d_erase", i), ne, tbl[i].n_erase);
            chk($sformatf("vec%0d_draw", i), nd, tbl[i].n_draw);
            chk($sformatf("vec%0d_alive", i), bus.alive, tbl[i].alive);
            chk($sformatf("vec%0d_x", i), bus.x_out, tbl[i].x);
            chk($sformatf("vec%0d_y", i), bus.y_out, tbl[i].y);
        end

        mx = tbl[18].x; my = tbl[18].y; malive = tbl[18].alive;
        hold_err = 0;
        for (int n = 0; n < 100; n++) begin
            c    = $urandom_range(1, 7);
            tick = $urandom_range(0, 1);
            up   = $urandom_range(0, 1);
            bv   = ($urandom_range(0, 2) == 0);
            bx   = (mx + int'($urandom_range(0, 12)) - 6) & 255;
            by   = (my + int'($urandom_range(0, 10)) - 6) & 127;
            rsp  = !malive && ($urandom_range(0, 1) == 1);
            sx   = $urandom_range(0, 200);
            sy   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 116));
            model_step(tick, up, bv, bx, by, rsp, sx, sy, c);
            apply(tick, up, bv, bx, by, rsp, sx, sy, c);
            run_idle($sformatf("rnd%0d", n), 1'b1);
            compare_q($sformatf("rnd%0d_pixels", n));
            chk($sformatf("rnd%0d_x", n), bus.x_out, mx);
            chk($sformatf("rnd%0d_y", n), bus.y_out, my);
            chk($sformatf("rnd%0d_alive", n), bus.alive, malive);
        end
        chk("rnd_hold", hold_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
